// File: rtl/jelly2_texture_cache_arbiter_pkg.sv
// Shared sizing helpers for the texture cache arbiter.
// The AR payload struct depends on module parameters, so the top declares
// ar_payload_t locally using these helpers.
package jelly2_texture_cache_arbiter_pkg;

    // Width of a requester index; a single requester still needs one bit.
    function automatic int calc_id_width(input int s_num);
        return (s_num > 1) ? $clog2(s_num) : 1;
    endfunction

    // Width able to hold 0..max_outstanding inclusive.
    function automatic int calc_cnt_width(input int max_outstanding);
        return $clog2(max_outstanding + 1);
    endfunction

endpackage

// File: rtl/jelly2_rr_arbiter.sv
// Round-robin grant: first requesting index at or after ptr, wrapping mod N.
module jelly2_rr_arbiter #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_id,
    output logic           grant_valid
);

    int idx;

    // Scan from ptr upwards; the first hit wins, so grant is one-hot.
    always_comb begin
        grant       = '0;
        grant_id    = '0;
        grant_valid = 1'b0;
        idx         = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant[idx]  = 1'b1;
                grant_id    = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/jelly2_texture_cache_arbiter.sv
// Shares one texture cache read port among S_NUM requesters.
// Round-robin AR arbitration into a registered output stage, requester id
// tagged into m_aruser, responses routed back by that id, per-requester
// outstanding counters bounding occupancy.
// Optional: define JELLY2_TEXTURE_CACHE_ARBITER_ASSERT_EN for simulation checks.
module jelly2_texture_cache_arbiter
    import jelly2_texture_cache_arbiter_pkg::*;
#(
    parameter  int S_NUM           = 4,
    parameter  int S_USER_WIDTH    = 1,
    parameter  int ADDR_X_WIDTH    = 12,
    parameter  int ADDR_Y_WIDTH    = 12,
    parameter  int DATA_WIDTH      = 24,
    parameter  int MAX_OUTSTANDING = 16,
    localparam int ID_WIDTH        = calc_id_width(S_NUM),
    localparam int M_USER_WIDTH    = ID_WIDTH + S_USER_WIDTH
) (
    input  logic                                reset,
    input  logic                                clk,

    input  logic [S_NUM-1:0][S_USER_WIDTH-1:0]  s_aruser,
    input  logic [S_NUM-1:0][ADDR_X_WIDTH-1:0]  s_araddrx,
    input  logic [S_NUM-1:0][ADDR_Y_WIDTH-1:0]  s_araddry,
    input  logic [S_NUM-1:0]                    s_arstrb,
    input  logic [S_NUM-1:0]                    s_arvalid,
    output logic [S_NUM-1:0]                    s_arready,

    output logic [S_USER_WIDTH-1:0]             s_ruser,
    output logic                                s_rlast,
    output logic [DATA_WIDTH-1:0]               s_rdata,
    output logic                                s_rstrb,
    output logic [S_NUM-1:0]                    s_rvalid,
    input  logic [S_NUM-1:0]                    s_rready,

    output logic [M_USER_WIDTH-1:0]             m_aruser,
    output logic [ADDR_X_WIDTH-1:0]             m_araddrx,
    output logic [ADDR_Y_WIDTH-1:0]             m_araddry,
    output logic                                m_arstrb,
    output logic                                m_arvalid,
    input  logic                                m_arready,

    input  logic [M_USER_WIDTH-1:0]             m_ruser,
    input  logic                                m_rlast,
    input  logic [DATA_WIDTH-1:0]               m_rdata,
    input  logic                                m_rstrb,
    input  logic                                m_rvalid,
    output logic                                m_rready,

    output logic                                busy
);

    localparam int CNT_WIDTH = calc_cnt_width(MAX_OUTSTANDING);

    typedef struct packed {
        logic [S_USER_WIDTH-1:0] user;
        logic [ADDR_X_WIDTH-1:0] x;
        logic [ADDR_Y_WIDTH-1:0] y;
        logic                    strb;
    } ar_payload_t;

    logic [S_NUM-1:0][CNT_WIDTH-1:0] cnt;
    logic [S_NUM-1:0]                eligible;
    logic [S_NUM-1:0]                grant;
    logic [ID_WIDTH-1:0]             grant_id;
    logic                            grant_valid;
    logic [ID_WIDTH-1:0]             rr_ptr;
    logic                            load;
    ar_payload_t                     ar_sel;
    ar_payload_t                     ar_reg;
    logic [ID_WIDTH-1:0]             ar_id;
    logic [ID_WIDTH-1:0]             r_id;
    logic [S_NUM-1:0]                cnt_inc;
    logic [S_NUM-1:0]                cnt_dec;
    logic [S_NUM-1:0]                cnt_nz;

    // A requester at its in-flight limit drops out of arbitration.
    always_comb begin
        eligible = '0;
        cnt_nz   = '0;
        for (int i = 0; i < S_NUM; i++) begin
            eligible[i] = s_arvalid[i] && (cnt[i] != CNT_WIDTH'(MAX_OUTSTANDING));
            cnt_nz[i]   = (cnt[i] != '0);
        end
    end

    jelly2_rr_arbiter #(
        .N   (S_NUM),
        .IDW (ID_WIDTH)
    ) u_rr_arbiter (
        .req         (eligible),
        .ptr         (rr_ptr),
        .grant       (grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid)
    );

    assign load      = !m_arvalid || m_arready;
    assign s_arready = grant & {S_NUM{load}};

    assign ar_sel = '{user: s_aruser[grant_id], x: s_araddrx[grant_id],
                      y: s_araddry[grant_id], strb: s_arstrb[grant_id]};

    // Output register stage; pointer moves past the winner only when it is taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_arvalid <= 1'b0;
            rr_ptr    <= '0;
            ar_reg    <= '0;
            ar_id     <= '0;
        end else if (load) begin
            m_arvalid <= grant_valid;
            if (grant_valid) begin
                ar_reg <= ar_sel;
                ar_id  <= grant_id;
                rr_ptr <= (grant_id == ID_WIDTH'(S_NUM - 1)) ? '0 : grant_id + 1'b1;
            end
        end
    end

    assign m_aruser  = {ar_id, ar_reg.user};
    assign m_araddrx = ar_reg.x;
    assign m_araddry = ar_reg.y;
    assign m_arstrb  = ar_reg.strb;

    // Response routing by the id tag; an out-of-range id is swallowed.
    assign r_id = m_ruser[M_USER_WIDTH-1 -: ID_WIDTH];
    always_comb begin
        s_rvalid = '0;
        m_rready = 1'b1;
        for (int i = 0; i < S_NUM; i++) begin
            if (r_id == ID_WIDTH'(i)) begin
                s_rvalid[i] = m_rvalid;
                m_rready    = s_rready[i];
            end
        end
    end

    assign s_ruser = m_ruser[S_USER_WIDTH-1:0];
    assign s_rlast = m_rlast;
    assign s_rdata = m_rdata;
    assign s_rstrb = m_rstrb;

    assign cnt_inc = s_arvalid & s_arready;
    assign cnt_dec = s_rvalid & s_rready & {S_NUM{m_rlast}};

    // Outstanding counters: a request and a final beat in the same cycle cancel.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            for (int i = 0; i < S_NUM; i++) begin
                if (cnt_inc[i] && !cnt_dec[i]) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end else if (cnt_dec[i] && !cnt_inc[i]) begin
                    cnt[i] <= cnt[i] - 1'b1;
                end
            end
        end
    end

    assign busy = m_arvalid || (|cnt_nz);

`ifdef JELLY2_TEXTURE_CACHE_ARBITER_ASSERT_EN
    logic                                                      hold_q;
    logic [M_USER_WIDTH+ADDR_X_WIDTH+ADDR_Y_WIDTH:0]           payload_q;

    // Protocol sanity checks on counters, response ids and AR stability.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q    <= 1'b0;
            payload_q <= '0;
        end else begin
            for (int i = 0; i < S_NUM; i++) begin
                if (cnt_dec[i] && cnt[i] == '0)
                    $error("arbiter: counter underflow on port %0d", i);
                if (cnt_inc[i] && !cnt_dec[i] && cnt[i] == CNT_WIDTH'(MAX_OUTSTANDING))
                    $error("arbiter: counter overflow on port %0d", i);
            end
            if (m_rvalid && int'(r_id) >= S_NUM)
                $error("arbiter: response id %0d out of range", r_id);
            if (hold_q && payload_q != {m_aruser, m_araddrx, m_araddry, m_arstrb})
                $error("arbiter: m_ar payload changed while stalled");
            hold_q    <= m_arvalid && !m_arready;
            payload_q <= {m_aruser, m_araddrx, m_araddry, m_arstrb};
        end
    end
`endif

endmodule
